// File: rtl/pmp_scan_ctrl.sv
// PMP scan controller: walks the PMP entries one per cycle and
// reports the first-match permission check for a single request.
package pmp_scan_pkg;
  typedef struct packed {
    logic       l;
    logic [1:0] res;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;
endpackage

module pmp_scan_ctrl
  import pmp_scan_pkg::*;
#(
  parameter int PMP_CNT = 16,
  parameter int PLEN    = 34
) (
  input  logic            clock,
  input  logic            reset_n,
  input  pmpcfg_t         io_pmpcfg  [PMP_CNT],
  input  logic [31:0]     io_pmpaddr [PMP_CNT],
  input  logic            io_req_valid,
  output logic            io_req_ready,
  input  logic [PLEN-1:0] io_addr,
  input  logic [1:0]      io_size,
  input  logic [1:0]      io_prv,
  input  logic            io_r,
  input  logic            io_w,
  input  logic            io_x,
  output logic            io_resp_valid,
  input  logic            io_resp_ready,
  output logic            io_exception,
  input  logic            io_flush,
  output logic            io_busy
);

  localparam int IW = (PMP_CNT > 1) ? $clog2(PMP_CNT) : 1;
  localparam logic [IW-1:0] LAST = IW'(PMP_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   a_q, a_d;
  logic [1:0]    prv_q, prv_d;
  logic [2:0]    rwx_q, rwx_d;
  logic          exc_q, exc_d;
  logic          rv_q, rv_d;

  pmpcfg_t       cfg;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   napot_mask;
  logic          hit;
  logic          deny;
  logic          hit_exc;
  logic          unused_ok;

  // Current entry; TOR lower bound comes from the previous entry.
  always_comb begin
    cfg        = io_pmpcfg[idx_q];
    hi         = io_pmpaddr[idx_q];
    lo         = '0;
    if (idx_q != '0) begin
      lo = io_pmpaddr[idx_q - IW'(1)];
    end
    napot_mask = ~(hi ^ (hi + 32'd1));
    hit        = 1'b0;
    unique case (cfg.a)
      2'd0: hit = 1'b0;
      2'd1: hit = (a_q >= lo) && (a_q < hi);
      2'd2: hit = (a_q == hi);
      2'd3: hit = ((a_q ^ hi) & napot_mask) == '0;
      default: hit = 1'b0;
    endcase
    deny    = |(rwx_q & ~{cfg.x, cfg.w, cfg.r});
    hit_exc = ((prv_q == 2'd3) && !cfg.l) ? 1'b0 : deny;
  end

  assign unused_ok = ^{io_size, io_addr[1:0], cfg.res};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    prv_d   = prv_q;
    rwx_d   = rwx_q;
    exc_d   = exc_q;
    rv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io_req_valid && io_req_ready) begin
          a_d     = 32'(io_addr[PLEN-1:2]);
          prv_d   = io_prv;
          rwx_d   = {io_x, io_w, io_r};
          idx_d   = '0;
          exc_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (io_flush) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (hit) begin
          exc_d   = hit_exc;
          state_d = RESP;
        end else if (idx_q == LAST) begin
          exc_d   = (prv_q != 2'd3);
          state_d = RESP;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      RESP: begin
        // Flush takes priority over a completing response handshake.
        if (io_flush || (rv_q && io_resp_ready)) begin
          idx_d   = '0;
          exc_d   = 1'b0;
          state_d = IDLE;
        end else begin
          rv_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      prv_q   <= '0;
      rwx_q   <= '0;
      exc_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      prv_q   <= prv_d;
      rwx_q   <= rwx_d;
      exc_q   <= exc_d;
      rv_q    <= rv_d;
    end
  end

  assign io_req_ready  = reset_n & (state_q == IDLE) & ~io_flush;
  assign io_resp_valid = rv_q;
  assign io_exception  = rv_q & exc_q;
  assign io_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pmp_scan_ctrl.sv
// Bench for pmp_scan_ctrl: per-cycle comparison against a
// transaction-level model plus directed literal checks.
module tb_pmp_scan_ctrl;
  import pmp_scan_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  pmpcfg_t     cfg   [16];
  logic [31:0] paddr [16];
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic [33:0] io_addr = '0;
  logic [1:0]  io_size = '0;
  logic [1:0]  io_prv = '0;
  logic        io_r = 1'b0;
  logic        io_w = 1'b0;
  logic        io_x = 1'b0;
  logic        io_resp_valid;
  logic        io_resp_ready = 1'b0;
  logic        io_exception;
  logic        io_flush = 1'b0;
  logic        io_busy;

  int checks = 0;
  int errors = 0;

  bit m_busy = 1'b0;
  bit m_rv   = 1'b0;
  bit m_exc  = 1'b0;
  int m_cnt  = 0;
  int mk;
  bit me;

  pmp_scan_ctrl #(.PMP_CNT(16), .PLEN(34)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_pmpcfg    (cfg),
    .io_pmpaddr   (paddr),
    .io_req_valid (io_req_valid),
    .io_req_ready (io_req_ready),
    .io_addr      (io_addr),
    .io_size      (io_size),
    .io_prv       (io_prv),
    .io_r         (io_r),
    .io_w         (io_w),
    .io_x         (io_x),
    .io_resp_valid(io_resp_valid),
    .io_resp_ready(io_resp_ready),
    .io_exception (io_exception),
    .io_flush     (io_flush),
    .io_busy      (io_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic pmpcfg_t mkcfg(input bit l, input logic [1:0] a,
                                    input logic [2:0] xwr);
    return {l, 2'b00, a, xwr};
  endfunction

  // Decide which entry settles the request and its outcome.
  function automatic void model_eval(input logic [31:0] a,
                                     input logic [1:0] prv,
                                     input bit r, input bit w, input bit x,
                                     output int k, output bit exc);
    k   = 15;
    exc = (prv != 2'd3);
    for (int i = 0; i < 16; i++) begin
      bit m;
      logic [31:0] lo;
      int t;
      m  = 1'b0;
      lo = 32'd0;
      if (i > 0) lo = paddr[i-1];
      case (cfg[i].a)
        2'd1: m = (lo <= a) && (a < paddr[i]);
        2'd2: m = (a == paddr[i]);
        2'd3: begin
          t = 0;
          while (t < 32 && paddr[i][t]) t++;
          if (t >= 31) m = 1'b1;
          else m = ((a >> (t + 1)) == (paddr[i] >> (t + 1)));
        end
        default: m = 1'b0;
      endcase
      if (m) begin
        k = i;
        if (prv == 2'd3 && !cfg[i].l) exc = 1'b0;
        else exc = (r && !cfg[i].r) || (w && !cfg[i].w) ||
                   (x && !cfg[i].x);
        return;
      end
    end
  endfunction

  // Transaction model: result appears k+2 edges after acceptance.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0;
      m_rv   = 1'b0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (io_req_valid && !io_flush) begin
        model_eval(io_addr[33:2], io_prv, io_r, io_w, io_x, mk, me);
        m_exc  = me;
        m_cnt  = mk + 2;
        m_busy = 1'b1;
      end
    end else if (io_flush) begin
      m_busy = 1'b0;
      m_rv   = 1'b0;
    end else if (m_rv && io_resp_ready) begin
      m_busy = 1'b0;
      m_rv   = 1'b0;
    end else if (!m_rv) begin
      m_cnt--;
      if (m_cnt == 0) m_rv = 1'b1;
    end
  end

  always @(negedge clock) begin
    check("ready", io_req_ready, reset_n && !m_busy && !io_flush);
    check("busy", io_busy, m_busy);
    check("resp_valid", io_resp_valid, m_rv);
    if (m_rv) check("exception", io_exception, m_exc);
  end

  task automatic clear_cfg();
    for (int i = 0; i < 16; i++) begin
      cfg[i]   = '0;
      paddr[i] = '0;
    end
  endtask

  task automatic issue(input logic [33:0] addr, input logic [1:0] prv,
                       input bit r, input bit w, input bit x);
    io_addr      = addr;
    io_prv       = prv;
    io_r         = r;
    io_w         = w;
    io_x         = x;
    io_req_valid = 1'b1;
    @(posedge clock);
    #1 io_req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      #1;
      if (io_resp_valid) break;
    end
  endtask

  task automatic do_req(input string nm, input logic [33:0] addr,
                        input logic [1:0] prv, input bit r, input bit w,
                        input bit x, input int exp_lat, input bit exp_exc);
    int n;
    issue(addr, prv, r, w, x);
    wait_resp(n);
    check({nm, "_lat"}, n, exp_lat);
    check({nm, "_exc"}, io_exception, exp_exc);
    io_resp_ready = 1'b1;
    @(posedge clock);
    #1 io_resp_ready = 1'b0;
    check({nm, "_idle"}, io_busy, 0);
  endtask

  initial begin
    int n;
    bit saw;
    bit held;
    clear_cfg();
    #1 reset_n = 1'b0;
    #2;
    check("rst_busy", io_busy, 0);
    check("rst_rv", io_resp_valid, 0);
    check("rst_exc", io_exception, 0);
    check("rst_ready", io_req_ready, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rel_ready", io_req_ready, 1);
    @(posedge clock);
    #1;

    clear_cfg();
    cfg[2]   = mkcfg(0, 2'd2, 3'b001);
    paddr[2] = 32'h100;
    do_req("na4_rd", 34'h400, 2'd0, 1, 0, 0, 4, 0);
    do_req("na4_wr", 34'h400, 2'd0, 0, 1, 0, 4, 1);

    clear_cfg();
    do_req("off_s", 34'h1000, 2'd1, 1, 0, 0, 17, 1);
    do_req("off_m", 34'h1000, 2'd3, 1, 0, 0, 17, 0);

    clear_cfg();
    cfg[0]   = mkcfg(1, 2'd1, 3'b000);
    paddr[0] = 32'h40;
    do_req("tor_lock", 34'hFC, 2'd3, 0, 0, 1, 2, 1);
    do_req("tor_edge", 34'h100, 2'd3, 0, 0, 1, 17, 0);

    clear_cfg();
    cfg[1]   = mkcfg(0, 2'd3, 3'b011);
    paddr[1] = 32'h1FF;
    cfg[3]   = mkcfg(0, 2'd2, 3'b000);
    paddr[3] = 32'h1FF;
    do_req("prio", 34'h7FC, 2'd0, 1, 0, 0, 3, 0);
    do_req("napot_out", 34'h1000, 2'd0, 1, 0, 0, 17, 1);

    clear_cfg();
    cfg[0]   = mkcfg(0, 2'd3, 3'b010);
    paddr[0] = 32'hFFFF_FFFF;
    do_req("wo_wr", 34'h1234, 2'd0, 0, 1, 0, 2, 0);
    do_req("wo_rd", 34'h1234, 2'd0, 1, 0, 0, 2, 1);

    clear_cfg();
    paddr[0] = 32'h100;
    cfg[1]   = mkcfg(0, 2'd1, 3'b111);
    paddr[1] = 32'h200;
    do_req("tor1_in", 34'h540, 2'd0, 0, 0, 1, 3, 0);
    do_req("tor1_out", 34'h940, 2'd0, 0, 0, 1, 17, 1);

    clear_cfg();
    issue(34'h80, 2'd1, 1, 0, 0);
    repeat (3) @(posedge clock);
    #1 io_flush = 1'b1;
    @(posedge clock);
    #1 io_flush = 1'b0;
    check("flush_busy", io_busy, 0);
    check("flush_rv", io_resp_valid, 0);
    saw = 1'b0;
    repeat (20) begin
      @(posedge clock);
      #1 if (io_resp_valid) saw = 1'b1;
    end
    check("flush_noresp", saw, 0);

    issue(34'h80, 2'd1, 1, 0, 0);
    wait_resp(n);
    check("hold_lat", n, 17);
    held = 1'b1;
    repeat (5) begin
      @(posedge clock);
      #1 if (!io_resp_valid || !io_exception) held = 1'b0;
    end
    check("hold_stable", held, 1);
    io_flush      = 1'b1;
    io_resp_ready = 1'b1;
    @(posedge clock);
    #1;
    io_flush      = 1'b0;
    io_resp_ready = 1'b0;
    check("flush_resp_rv", io_resp_valid, 0);
    check("flush_resp_busy", io_busy, 0);

    issue(34'h80, 2'd1, 1, 0, 0);
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", io_busy, 0);
    check("mid_rst_rv", io_resp_valid, 0);
    check("mid_rst_ready", io_req_ready, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("mid_rel_ready", io_req_ready, 1);
    @(posedge clock);
    #1;
    do_req("after_rst", 34'h80, 2'd3, 1, 0, 0, 17, 0);

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
